// File: rtl/bcd_scan_counter_if.sv
// Counter control and display-scan bundle between a controller (master) and bcd_scan_counter (slave).
interface bcd_scan_counter_if #(
  parameter int DIGITS = 4
);
  logic                  step;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  carry;
  logic [3:0]            digit;
  logic [DIGITS-1:0]     sel;
  logic                  blank;

  modport master (
    output step, up, load, load_val,
    input  count, carry, digit, sel, blank
  );

  modport slave (
    input  step, up, load, load_val,
    output count, carry, digit, sel, blank
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a free-running digit scanner that feeds
// a single seven-segment decoder one nibble at a time, with leading-zero blanking.
module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_scan_counter_if.slave   bus
);

  localparam int IDX_W = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW    = 4 * DIGITS;

  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;

  logic [CW-1:0]    inc_val, dec_val, load_clean;
  logic             inc_wrap, dec_wrap;
  logic [3:0]       digit_w;
  logic             blank_w;

  // Out-of-range nibbles are forced to 0 so the count always holds legal BCD.
  function automatic logic [CW-1:0] sanitize(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd0 : v[4*i +: 4];
    end
    return r;
  endfunction

  always_comb begin
    logic c_inc, c_dec;
    logic [3:0] nib;
    inc_val = '0;
    dec_val = '0;
    c_inc   = 1'b1;
    c_dec   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nib = count_q[4*i +: 4];
      if (c_inc) begin
        if (nib == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = nib + 4'd1;
          c_inc             = 1'b0;
        end
      end else begin
        inc_val[4*i +: 4] = nib;
      end
      if (c_dec) begin
        if (nib == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = nib - 4'd1;
          c_dec             = 1'b0;
        end
      end else begin
        dec_val[4*i +: 4] = nib;
      end
    end
    // A ripple that runs off the top digit is the wrap.
    inc_wrap   = c_inc;
    dec_wrap   = c_dec;
    load_clean = sanitize(bus.load_val);
  end

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (bus.load) begin
      count_d = load_clean;
    end else if (bus.step) begin
      count_d = bus.up ? inc_val  : dec_val;
      carry_d = bus.up ? inc_wrap : dec_wrap;
    end
  end

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Walk from the top digit down so all_zero covers everything at or above the scanned digit.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    digit_w  = 4'd0;
    blank_w  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (count_q[4*i +: 4] == 4'd0);
      if (idx_q == IDX_W'(i)) begin
        digit_w = count_q[4*i +: 4];
        blank_w = all_zero && (i != 0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      div_q   <= '0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
    end
  end

  assign bus.count = count_q;
  assign bus.carry = carry_q;
  assign bus.digit = digit_w;
  assign bus.sel   = DIGITS'(1) << idx_q;
  assign bus.blank = blank_w;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter (DIGITS=4, SCAN_DIV=4): reset, wraps, load rules, scan and blanking.
module tb_bcd_scan_counter;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;   // edges since the last reset edge, models the scanner

  bcd_scan_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic ld, input logic [15:0] v, input logic st, input logic u);
    bus.load     = ld;
    bus.load_val = v;
    bus.step     = st;
    bus.up       = u;
  endtask

  int dig42 [4] = '{2, 4, 0, 0};
  int blk42 [4] = '{0, 0, 1, 1};

  initial begin
    int idx;
    rst = 1'b1;
    drive(1'b1, 16'h1234, 1'b1, 1'b1);
    @(negedge clk);
    tick();
    check("rst_count", bus.count, 32'h0);
    check("rst_sel",   bus.sel,   32'h1);
    check("rst_digit", bus.digit, 32'h0);
    check("rst_blank", bus.blank, 32'h0);
    check("rst_carry", bus.carry, 32'h0);
    rst = 1'b0;

    // Up wrap
    drive(1'b1, 16'h9998, 1'b0, 1'b1);
    tick();
    check("ld9998", bus.count, 32'h9998);
    drive(1'b0, 16'h0, 1'b1, 1'b1);
    tick();
    check("up1_count", bus.count, 32'h9999);
    check("up1_carry", bus.carry, 32'h0);
    tick();
    check("up2_count", bus.count, 32'h0000);
    check("up2_carry", bus.carry, 32'h1);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    check("hold_count", bus.count, 32'h0000);
    check("hold_carry", bus.carry, 32'h0);

    // Down wrap, then an ordinary borrow-free decrement
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    check("dn1_count", bus.count, 32'h9999);
    check("dn1_carry", bus.carry, 32'h1);
    tick();
    check("dn2_count", bus.count, 32'h9998);
    check("dn2_carry", bus.carry, 32'h0);

    // Invalid nibbles load as zero
    drive(1'b1, 16'h12AF, 1'b0, 1'b1);
    tick();
    check("ld_inv_count", bus.count, 32'h1200);
    check("ld_inv_carry", bus.carry, 32'h0);
    drive(1'b0, 16'h0, 1'b1, 1'b1);
    tick();
    check("inc_after_inv", bus.count, 32'h1201);

    // Load wins over a step that would otherwise wrap
    drive(1'b1, 16'h9999, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'h0500, 1'b1, 1'b1);
    tick();
    check("coll_count", bus.count, 32'h0500);
    check("coll_carry", bus.carry, 32'h0);

    // Scanner re-synchronised by reset so the first scanned cycle is digit 0
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 16'h0042, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      idx = (cyc / SCAN_DIV) % DIGITS;
      check($sformatf("scan42_sel_%0d", k),   bus.sel,   32'(1 << idx));
      check($sformatf("scan42_dig_%0d", k),   bus.digit, 32'(dig42[idx]));
      check($sformatf("scan42_blank_%0d", k), bus.blank, 32'(blk42[idx]));
      tick();
    end
    idx = (cyc / SCAN_DIV) % DIGITS;
    check("scan_full_cycle_sel", bus.sel, 32'(1 << idx));

    drive(1'b1, 16'h0000, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      idx = (cyc / SCAN_DIV) % DIGITS;
      check($sformatf("scan0_blank_%0d", k), bus.blank, (idx != 0) ? 32'h1 : 32'h0);
      check($sformatf("scan0_dig_%0d", k),   bus.digit, 32'h0);
      tick();
    end

    // Mid-count, mid-scan reset with load and step asserted
    drive(1'b1, 16'h0077, 1'b0, 1'b1);
    tick();
    tick();
    drive(1'b1, 16'h1234, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check("mid_rst_count", bus.count, 32'h0);
    check("mid_rst_sel",   bus.sel,   32'h1);
    check("mid_rst_carry", bus.carry, 32'h0);
    check("mid_rst_blank", bus.blank, 32'h0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Multi-digit BCD up/down counter with a time-multiplexed digit scanner. It sits directly upstream of the single-digit BCD-to-seven-segment decoder. It holds a DIGITS-wide packed BCD value and presents one digit nibble at a time on `digit`, which feeds the decoder's 4-bit input. `sel` is the matching one-hot digit enable, and `blank` is a leading-zero suppression flag. The same counter drives every digit of a multiplexed display.

## Interface

Parameters:
- DIGITS, 4, number of BCD digits (≥1); digit 0 is least significant
- SCAN_DIV, 4, clock cycles each digit stays selected (≥1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high; overrides all other inputs
- step  input  1  count by one this cycle
- up  input  1  direction when step=1: 1 increment, 0 decrement
- load  input  1  load `load_val` this cycle; priority over step
- load_val  input  4*DIGITS  packed BCD value, nibble i = digit i
- count  output  4*DIGITS  current packed BCD value (registered)
- carry  output  1  one-cycle pulse on wrap (carry on up, borrow on down)
- digit  output  4  BCD nibble of currently scanned digit, to decoder input
- sel  output  DIGITS  one-hot select of currently scanned digit
- blank  output  1  1 = scanned digit is a leading zero, suppress display

## Operation

- Reset values: count=0, carry=0, scan index=0, sel=…0001, scan divider=0, digit=0, blank=0.
- Priority per cycle: rst > load > step > hold.
- Load:
  - Each nibble of load_val greater than 9 is stored as 0; valid nibbles are stored as given.
  - No carry is generated by a load.
  - The scan state is unaffected.
- Increment (step=1, up=1):
  - Ripple BCD add of 1. A digit at 9 becomes 0 and propagates to the next digit.
  - All-nines becomes all-zeros and sets carry=1 in the next cycle.
- Decrement (step=1, up=0):
  - Ripple BCD subtract of 1. A digit at 0 becomes 9 and borrows from the next digit.
  - All-zeros becomes all-nines and sets carry=1 in the next cycle.
- carry is registered and is high for exactly one cycle per wrap. Consecutive wrapping steps produce one pulse per step.
- Scanner:
  - A free-running divider counts 0..SCAN_DIV-1.
  - On the cycle the divider is at SCAN_DIV-1, it returns to 0 and the scan index advances: DIGITS-1 wraps to 0, and sel rotates left with wrap.
  - With SCAN_DIV=1 the index advances every cycle.
  - The scanner runs continuously; step and load do not affect it.
- digit = nibble[scan index] of count. It is purely a function of registered state, with no combinational path from inputs.
- blank = 1 iff scan index > 0 and every nibble from the scan index up to DIGITS-1 is zero. Digit 0 is never blanked, so value 0 shows a single "0".

## Timing

- count, carry, and the scan index are updated on the rising edge at which the inputs are sampled. The new values are visible in the following cycle.
- digit, sel, and blank change only after a clock edge, in the same cycle as the register change that causes them. A count change is reflected on digit as soon as count changes if that digit is currently selected.
- Each digit is selected for exactly SCAN_DIV consecutive cycles. A full refresh takes DIGITS*SCAN_DIV cycles.
- step may be held high: the counter advances once per cycle.
- load and step together: load wins, the step is dropped, and carry=0.
- rst asserted mid-count or mid-scan: on the next edge the state is exactly the reset state, regardless of load/step.

## Test plan

- Reset (DIGITS=4, SCAN_DIV=4): assert rst with load=1, load_val=0x1234 → count=0x0000, sel=0001, digit=0, blank=0, carry=0.
- Up wrap: load 0x9998, then step up twice → count 0x9999, then 0x0000. carry=1 only in the cycle after the second step.
- Down wrap: count 0x0000, step down once → count 0x9999, carry single pulse. Step down again → 0x9998, carry=0.
- Invalid load: load_val=0x12AF → count=0x1200. Then step up → 0x1201.
- Scan/blank: count 0x0042, run 16 cycles:
  - sel goes 0001, 0010, 0100, 1000, 4 cycles each, then back to 0001.
  - digit follows 2, 4, 0, 0.
  - blank follows 0, 0, 1, 1.
  - With count 0x0000, blank is 0 only while sel=0001.
- Collision: load=1 and step=1 with load_val=0x0500 → count=0x0500, carry=0.
